// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: grants up to NPORTS of NLANES writeback requests per
// cycle onto register-file write ports, round-robin from a rotating pointer,
// refusing any lane whose destination matches a lane already granted.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   req_valid/ready    per-lane handshake; ready is combinational
//   req_addr/data/mask per-lane destination register, data, byte enables
//   W_en/addr/data/mask per-port registered write to the register file
//   conflict_stall     a valid lane was refused solely on an address match
module regfile_wb_arbiter #(
    parameter int unsigned NLANES = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NLANES-1:0]            req_valid,
    output logic [NLANES-1:0]            req_ready,
    input  logic [NLANES*AW-1:0]         req_addr,
    input  logic [NLANES*DW-1:0]         req_data,
    input  logic [NLANES*(DW/8)-1:0]     req_mask,
    output logic [NPORTS-1:0]            W_en,
    output logic [NPORTS*AW-1:0]         W_addr,
    output logic [NPORTS*DW-1:0]         W_data,
    output logic [NPORTS*(DW/8)-1:0]     W_mask,
    output logic                         conflict_stall
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned LW = (NLANES > 1) ? $clog2(NLANES) : 1;

    logic [LW-1:0]                 ptr_q,  ptr_d;
    logic [NPORTS-1:0]             en_q,   en_d;
    logic [NPORTS-1:0][AW-1:0]     addr_q, addr_d;
    logic [NPORTS-1:0][DW-1:0]     data_q, data_d;
    logic [NPORTS-1:0][MW-1:0]     mask_q, mask_d;

    logic [NLANES-1:0]             grant_c;
    logic                          stall_c;

    // Round-robin search from ptr; addr_d[0..n_grant-1] doubles as the list
    // of addresses already claimed this cycle for the conflict check.
    always_comb begin : arbitrate
        int   lane;
        int   n_grant;
        int   last_lane;
        logic hit;

        grant_c   = '0;
        stall_c   = 1'b0;
        en_d      = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        lane      = 0;
        n_grant   = 0;
        last_lane = 0;
        hit       = 1'b0;

        for (int i = 0; i < int'(NLANES); i++) begin
            lane = (int'(ptr_q) + i) % int'(NLANES);
            // No grants while in reset so a lane never believes it transferred.
            if (reset_n && req_valid[lane] && (n_grant < int'(NPORTS))) begin
                hit = 1'b0;
                for (int p = 0; p < int'(NPORTS); p++) begin
                    if ((p < n_grant) && (addr_d[p] == req_addr[lane*int'(AW) +: AW])) begin
                        hit = 1'b1;
                    end
                end
                if (hit) begin
                    stall_c = 1'b1;
                end else begin
                    grant_c[lane]   = 1'b1;
                    en_d[n_grant]   = 1'b1;
                    addr_d[n_grant] = req_addr[lane*int'(AW) +: AW];
                    data_d[n_grant] = req_data[lane*int'(DW) +: DW];
                    mask_d[n_grant] = req_mask[lane*int'(MW) +: MW];
                    n_grant         = n_grant + 1;
                    last_lane       = lane;
                end
            end
        end

        if (n_grant > 0) begin
            ptr_d = LW'((last_lane + 1) % int'(NLANES));
        end
    end

    // Pointer and write-port registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            en_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign req_ready      = grant_c;
    assign conflict_stall = stall_c;
    assign W_en           = en_q;
    assign W_addr         = addr_q;
    assign W_data         = data_q;
    assign W_mask         = mask_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected write-port
// contents per granted cycle; a monitor pops and compares on every cycle with
// any W_en set. A port model tracks held values of idle ports.
module tb_regfile_wb_arbiter;

    localparam int NL = 8;
    localparam int NP = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int MW = 8;

    typedef struct packed {
        logic [NP-1:0]         en;
        logic [NP-1:0][AW-1:0] addr;
        logic [NP-1:0][DW-1:0] data;
        logic [NP-1:0][MW-1:0] mask;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    logic [NL-1:0]         req_valid = '0;
    logic [NL-1:0]         req_ready;
    logic [NL-1:0][AW-1:0] req_addr  = '0;
    logic [NL-1:0][DW-1:0] req_data  = '0;
    logic [NL-1:0][MW-1:0] req_mask  = '0;
    logic [NP-1:0]         W_en;
    logic [NP-1:0][AW-1:0] W_addr;
    logic [NP-1:0][DW-1:0] W_data;
    logic [NP-1:0][MW-1:0] W_mask;
    logic                  conflict_stall;

    logic [NL-1:0][AW-1:0] na;
    logic [NL-1:0][MW-1:0] nm;
    logic [NP-1:0][AW-1:0] model_addr;
    logic [NP-1:0][DW-1:0] model_data;
    logic [NP-1:0][MW-1:0] model_mask;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tnum   = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .NLANES(NL), .NPORTS(NP), .AW(AW), .DW(DW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .W_en           (W_en),
        .W_addr         (W_addr),
        .W_data         (W_data),
        .W_mask         (W_mask),
        .conflict_stall (conflict_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one arbitration cycle, check ready/stall, queue the expected ports.
    task automatic step(input logic [NL-1:0] valid, input logic [NL-1:0] exp_ready,
                        input logic exp_stall, input int n,
                        input int l0, input int l1, input int l2, input int l3,
                        input bit push);
        exp_t e;
        int   lanes[4];
        @(posedge clock);
        #1;
        tnum++;
        req_valid = valid;
        req_addr  = na;
        req_mask  = nm;
        for (int l = 0; l < NL; l++) begin
            req_data[l] = {32'hCAFE0000 | 32'(tnum), 32'(l)};
        end
        #1;
        chk($sformatf("ready_t%0d", tnum), 64'(req_ready), 64'(exp_ready));
        chk($sformatf("stall_t%0d", tnum), 64'(conflict_stall), 64'(exp_stall));
        lanes = '{l0, l1, l2, l3};
        e = '0;
        for (int k = 0; k < n; k++) begin
            e.en[k]   = 1'b1;
            e.addr[k] = req_addr[lanes[k]];
            e.data[k] = req_data[lanes[k]];
            e.mask[k] = req_mask[lanes[k]];
        end
        if (push) q.push_back(e);
    endtask

    task automatic expect_idle(input string name);
        @(posedge clock);
        #1;
        chk(name, 64'(W_en), 64'h0);
    endtask

    task automatic clear_model();
        model_addr = '0;
        model_data = '0;
        model_mask = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && (W_en != '0)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: W_en=%h with nothing queued", W_en);
                end else begin
                    e = q.pop_front();
                    chk("w_en", 64'(W_en), 64'(e.en));
                    for (int p = 0; p < NP; p++) begin
                        if (e.en[p]) begin
                            model_addr[p] = e.addr[p];
                            model_data[p] = e.data[p];
                            model_mask[p] = e.mask[p];
                        end
                        chk($sformatf("port%0d_addr", p), 64'(W_addr[p]), 64'(model_addr[p]));
                        chk($sformatf("port%0d_data", p), W_data[p], model_data[p]);
                        chk($sformatf("port%0d_mask", p), 64'(W_mask[p]), 64'(model_mask[p]));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        clear_model();
        na = '0;
        nm = '0;
        for (int l = 0; l < NL; l++) nm[l] = 8'h80 | 8'(l);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_w_en",   64'(W_en), 64'h0);
        chk("rst_w_addr", 64'(W_addr), 64'h0);
        chk("rst_w_data", 64'(W_data[0]), 64'h0);
        chk("rst_w_mask", 64'(W_mask), 64'h0);
        chk("rst_stall",  64'(conflict_stall), 64'h0);
        reset_n = 1'b1;

        // Saturation with rotation: lanes 0-3 then 4-7
        for (int l = 0; l < NL; l++) na[l] = 5'(8 + l);
        step(8'hFF, 8'h0F, 1'b0, 4, 0, 1, 2, 3, 1'b1);
        step(8'hFF, 8'hF0, 1'b0, 4, 4, 5, 6, 7, 1'b1);

        // Four distinct lanes from ptr=0
        na[0] = 5'd1; na[1] = 5'd2; na[2] = 5'd3; na[3] = 5'd4;
        step(8'h0F, 8'h0F, 1'b0, 4, 0, 1, 2, 3, 1'b1);

        // Idle: ptr stays at 4, shown by lane 5 outranking lane 0
        step(8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        expect_idle("idle_w_en_a");
        na[0] = 5'd20; na[5] = 5'd21;
        step(8'h21, 8'h21, 1'b0, 2, 5, 0, 0, 0, 1'b1);

        // Lane 7 alone brings ptr back to 0
        na[7] = 5'd9;
        step(8'h80, 8'h80, 1'b0, 1, 7, 0, 0, 0, 1'b1);

        // Address conflict: lanes 2 and 5 both target r7
        na[2] = 5'd7; na[5] = 5'd7;
        step(8'h24, 8'h04, 1'b1, 1, 2, 0, 0, 0, 1'b1);
        step(8'h20, 8'h20, 1'b0, 1, 5, 0, 0, 0, 1'b1);

        // Wrap-around from ptr=6
        na[6] = 5'd1; na[7] = 5'd2; na[0] = 5'd3;
        step(8'hC1, 8'hC1, 1'b0, 3, 6, 7, 0, 0, 1'b1);

        // Conflict plus saturation from ptr=1: lane 2 loses on address
        na[1] = 5'd3; na[2] = 5'd3; na[3] = 5'd4; na[4] = 5'd5;
        na[5] = 5'd6; na[6] = 5'd7; na[7] = 5'd8;
        step(8'hFE, 8'h3A, 1'b1, 4, 1, 3, 4, 5, 1'b1);

        // Match only after ports fill (ptr=6): no stall
        na[6] = 5'd10; na[7] = 5'd11; na[0] = 5'd12; na[1] = 5'd13; na[2] = 5'd10;
        step(8'hC7, 8'hC3, 1'b0, 4, 6, 7, 0, 1, 1'b1);

        // Idle, then a lone zero-mask lane (ports 1-3 must hold)
        step(8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        expect_idle("idle_w_en_b");
        na[4] = 5'd20; nm[4] = 8'h00;
        step(8'h10, 8'h10, 1'b0, 1, 4, 0, 0, 0, 1'b1);
        nm[4] = 8'h84;

        // Reset in the middle of a full burst
        na[0] = 5'd1; na[1] = 5'd2; na[2] = 5'd3; na[3] = 5'd4;
        step(8'h0F, 8'h0F, 1'b0, 4, 0, 1, 2, 3, 1'b0);
        @(posedge clock);
        #1;
        chk("burst_w_en", 64'(W_en), 64'hF);
        reset_n = 1'b0;
        #1;
        chk("async_rst_w_en",   64'(W_en), 64'h0);
        chk("async_rst_w_addr", 64'(W_addr), 64'h0);
        chk("async_rst_ready",  64'(req_ready), 64'h0);
        clear_model();
        @(posedge clock);
        #1;
        chk("held_rst_w_en", 64'(W_en), 64'h0);
        req_valid = '0;
        reset_n   = 1'b1;

        // First grant after release uses ptr=0
        na[1] = 5'd5; na[3] = 5'd6;
        step(8'h0A, 8'h0A, 1'b0, 2, 1, 3, 0, 0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        expect_idle("idle_w_en_c");
        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", 64'(q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
